// File: rtl/utm_pkg.sv
// utm_pkg -- shared definitions for the universal Turing machine datapath.
//   SYM_W        : width of one tape symbol
//   SYM_*        : the five legal tape symbols
//   is_valid_sym : 1 when a 3-bit code is one of the legal symbols
//   tape_state_e : control states of tape_store
package utm_pkg;

  localparam int SYM_W = 3;

  localparam logic [SYM_W-1:0] SYM_BLANK = 3'b000;
  localparam logic [SYM_W-1:0] SYM_1     = 3'b001;
  localparam logic [SYM_W-1:0] SYM_2     = 3'b010;
  localparam logic [SYM_W-1:0] SYM_4     = 3'b100;
  localparam logic [SYM_W-1:0] SYM_5     = 3'b101;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_FAULT  = 2'd3
  } tape_state_e;

  function automatic logic is_valid_sym(input logic [SYM_W-1:0] sym);
    logic ok;
    case (sym)
      SYM_BLANK, SYM_1, SYM_2, SYM_4, SYM_5: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tape_store_cells.sv
// tape_cell_array -- TAPE_LEN x SYM_W register file holding the tape.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, every cell -> BLANK
//   we_i    : write enable
//   waddr_i : write cell index
//   wdata_i : symbol to write
//   raddr_i : read cell index (combinational read)
//   rdata_o : symbol stored at raddr_i
module tape_cell_array
  import utm_pkg::*;
#(
  parameter int               TAPE_LEN = 16,
  parameter int               POS_W    = 4,
  parameter logic [SYM_W-1:0] BLANK    = 3'b000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [POS_W-1:0] waddr_i,
  input  logic [SYM_W-1:0] wdata_i,
  input  logic [POS_W-1:0] raddr_i,
  output logic [SYM_W-1:0] rdata_o
);

  logic [SYM_W-1:0] mem_q [TAPE_LEN];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < TAPE_LEN; i++) begin
        mem_q[i] <= BLANK;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tape_store.sv
// tape_store -- tape memory and head of the UTM datapath.
// Loads the initial tape serially, then per step writes {z2,z1,z0} under the
// head, moves the head, and re-reads the cell now under the head onto s2..s0.
//   clk, reset              : clock / asynchronous active-high reset
//   load_valid, load_sym    : serial tape load, head advances right
//   load_done               : end of load, head back to cell 0
//   step_valid / step_ready : step handshake (ready only in RUN)
//   z2, z1, z0, move_right  : symbol to write and head direction
//   s2, s1, s0              : registered symbol under the head
//   head_pos                : current head index
//   load_full               : load pointer has passed the last cell
//   fault                   : sticky error (bad symbol or head off the tape)
module tape_store
  import utm_pkg::*;
#(
  parameter int               TAPE_LEN = 16,
  parameter int               POS_W    = 4,
  parameter logic [SYM_W-1:0] BLANK    = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [2:0]       load_sym,
  input  logic             load_done,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic             z2,
  input  logic             z1,
  input  logic             z0,
  input  logic             move_right,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic [POS_W-1:0] head_pos,
  output logic             load_full,
  output logic             fault
);

  localparam logic [POS_W-1:0] HEAD_LAST = POS_W'(TAPE_LEN - 1);
  localparam logic [POS_W-1:0] HEAD_ONE  = POS_W'(1);

  tape_state_e      state_q, state_d;
  logic [POS_W-1:0] head_q, head_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             load_full_q, load_full_d;
  logic             fault_q, fault_d;

  logic             we;
  logic [SYM_W-1:0] wdata;
  logic [SYM_W-1:0] rdata;
  logic [SYM_W-1:0] z_sym;
  logic             off_end;

  assign z_sym   = {z2, z1, z0};
  assign off_end = move_right ? (head_q == HEAD_LAST) : (head_q == '0);

  // Read port follows head_d so the cell under the head after this edge is
  // already visible; in SETTLE head_d == head_q and the write has landed.
  tape_cell_array #(
    .TAPE_LEN (TAPE_LEN),
    .POS_W    (POS_W),
    .BLANK    (BLANK)
  ) u_cells (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (we),
    .waddr_i (head_q),
    .wdata_i (wdata),
    .raddr_i (head_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      head_q      <= '0;
      sym_q       <= SYM_BLANK;
      load_full_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      sym_q       <= sym_d;
      load_full_q <= load_full_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    sym_d       = sym_q;
    load_full_d = load_full_q;
    fault_d     = fault_q;
    we          = 1'b0;
    wdata       = z_sym;
    step_ready  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (load_done) begin
          head_d      = '0;
          load_full_d = 1'b0;
          state_d     = ST_SETTLE;
        end else if (load_valid && !load_full_q) begin
          we    = 1'b1;
          wdata = load_sym;
          // The last cell parks the pointer; further loads are dropped.
          if (head_q == HEAD_LAST) begin
            load_full_d = 1'b1;
          end else begin
            head_d = head_q + HEAD_ONE;
          end
        end
      end

      ST_SETTLE: begin
        sym_d   = rdata;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        step_ready = 1'b1;
        if (step_valid) begin
          if (!is_valid_sym(z_sym)) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            we = 1'b1;
            // Falling off the tape still commits the write, head stays put.
            if (off_end) begin
              fault_d = 1'b1;
              state_d = ST_FAULT;
            end else begin
              head_d  = move_right ? head_q + HEAD_ONE : head_q - HEAD_ONE;
              state_d = ST_SETTLE;
            end
          end
        end
      end

      default: begin
        // ST_FAULT: absorbing, everything held.
      end
    endcase
  end

  assign {s2, s1, s0} = sym_q;
  assign head_pos     = head_q;
  assign load_full    = load_full_q;
  assign fault        = fault_q;

endmodule
